// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master arbiter in front of a single IO register bus.
// One transaction is in flight at a time. An IDLE -> ISSUE -> (WAIT) -> DONE
// sequence runs for each transaction, with a round-robin choice between masters.
// Optional feature macro: IO_ARB_LOCK_EN. When it is defined, a master can keep
// the bus for up to HOLD_MAX consecutive transactions.
module io_bus_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int HOLD_MAX   = 4
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic        M0_Req,
  input  logic        M1_Req,
  input  logic        M0_Wr,
  input  logic        M1_Wr,
  input  logic [29:0] M0_Address,
  input  logic [29:0] M1_Address,
  input  logic [31:0] M0_WrData,
  input  logic [31:0] M1_WrData,
  input  logic        M0_Lock,
  input  logic        M1_Lock,
  output logic        M0_Grant,
  output logic        M1_Grant,
  output logic        M0_Done,
  output logic        M1_Done,
  output logic [31:0] M0_RdData,
  output logic [31:0] M1_RdData,
  output logic [29:0] Bus_Address,
  output logic [31:0] Bus_WrData,
  output logic        Bus_WrEn,
  output logic        Bus_RdEn,
  input  logic [31:0] Bus_RdData
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic       sel;        // master owning the transaction in flight
  logic       is_write;   // registered Wr of the winner
  logic       last;       // master served most recently (round-robin pointer)
  logic [2:0] wait_cnt;   // remaining WAIT cycles minus one
  logic       any_req;
  logic       rr_win;
  logic       win_next;

`ifdef IO_ARB_LOCK_EN
  localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

  logic          locked;     // last served master keeps priority
  logic [HW-1:0] hold;       // consecutive locked regrants so far
  logic          owner_req;
  logic          winner_lock;

  assign owner_req   = last ? M1_Req : M0_Req;
  assign winner_lock = sel ? M1_Lock : M0_Lock;

  // Lock state: set or released at DONE, dropped at IDLE if the owner has gone quiet.
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      locked <= 1'b0;
      hold   <= '0;
    end else if (state == DONE) begin
      if (winner_lock && (hold < HOLD_LIM)) begin
        locked <= 1'b1;
        hold   <= hold + HW'(1);
      end else begin
        locked <= 1'b0;
        hold   <= '0;
      end
    end else if ((state == IDLE) && locked && !owner_req) begin
      locked <= 1'b0;
      hold   <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = M0_Lock ^ M1_Lock ^ (HOLD_MAX > 0);
`endif

  // Winner selection: the master not served last wins a tie; a held lock overrides this.
  always_comb begin
    any_req = M0_Req | M1_Req;
    if (M0_Req && M1_Req) begin
      rr_win = ~last;
    end else if (M1_Req) begin
      rr_win = 1'b1;
    end else begin
      rr_win = 1'b0;
    end
`ifdef IO_ARB_LOCK_EN
    win_next = (locked && owner_req) ? last : rr_win;
`else
    win_next = rr_win;
`endif
  end

  // Transaction FSM with registered bus strobes, grants, done pulses and read data.
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state       <= IDLE;
      sel         <= 1'b0;
      is_write    <= 1'b0;
      last        <= 1'b1;   // pretend M1 went last so M0 is favoured
      wait_cnt    <= 3'd0;
      M0_Grant    <= 1'b0;
      M1_Grant    <= 1'b0;
      M0_Done     <= 1'b0;
      M1_Done     <= 1'b0;
      M0_RdData   <= 32'd0;
      M1_RdData   <= 32'd0;
      Bus_Address <= 30'd0;
      Bus_WrData  <= 32'd0;
      Bus_WrEn    <= 1'b0;
      Bus_RdEn    <= 1'b0;
    end else begin
      M0_Grant <= 1'b0;
      M1_Grant <= 1'b0;
      M0_Done  <= 1'b0;
      M1_Done  <= 1'b0;
      Bus_WrEn <= 1'b0;
      Bus_RdEn <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel         <= win_next;
            is_write    <= win_next ? M1_Wr : M0_Wr;
            Bus_Address <= win_next ? M1_Address : M0_Address;
            Bus_WrData  <= win_next ? M1_WrData : M0_WrData;
            M0_Grant    <= ~win_next;
            M1_Grant    <= win_next;
            Bus_WrEn    <= win_next ? M1_Wr : M0_Wr;
            Bus_RdEn    <= win_next ? ~M1_Wr : ~M0_Wr;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_write) begin
            M0_Done <= ~sel;
            M1_Done <= sel;
            state   <= DONE;
          end else begin
            wait_cnt <= 3'(RD_LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (sel) begin
              M1_RdData <= Bus_RdData;
            end else begin
              M0_RdData <= Bus_RdData;
            end
            M0_Done <= ~sel;
            M1_Done <= sel;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          last  <= sel;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed stimulus plus a transaction-schedule model that
// checks every DUT output on every cycle. It also makes literal checks for the
// key scenarios. The lock scenario's expectation follows IO_ARB_LOCK_EN.
module tb_io_bus_arbiter;

  localparam int L  = 2;
  localparam int HM = 2;

  logic        clk = 1'b0;
  logic        Sys_Reset;
  logic        M0_Req, M1_Req, M0_Wr, M1_Wr, M0_Lock, M1_Lock;
  logic [29:0] M0_Address, M1_Address;
  logic [31:0] M0_WrData, M1_WrData;
  logic        M0_Grant, M1_Grant, M0_Done, M1_Done;
  logic [31:0] M0_RdData, M1_RdData;
  logic [29:0] Bus_Address;
  logic [31:0] Bus_WrData;
  logic        Bus_WrEn, Bus_RdEn;
  logic [31:0] Bus_RdData;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(.RD_LATENCY(L), .HOLD_MAX(HM)) dut (
    .Sys_Clock(clk), .Sys_Reset(Sys_Reset),
    .M0_Req(M0_Req), .M1_Req(M1_Req), .M0_Wr(M0_Wr), .M1_Wr(M1_Wr),
    .M0_Address(M0_Address), .M1_Address(M1_Address),
    .M0_WrData(M0_WrData), .M1_WrData(M1_WrData),
    .M0_Lock(M0_Lock), .M1_Lock(M1_Lock),
    .M0_Grant(M0_Grant), .M1_Grant(M1_Grant), .M0_Done(M0_Done), .M1_Done(M1_Done),
    .M0_RdData(M0_RdData), .M1_RdData(M1_RdData),
    .Bus_Address(Bus_Address), .Bus_WrData(Bus_WrData),
    .Bus_WrEn(Bus_WrEn), .Bus_RdEn(Bus_RdEn), .Bus_RdData(Bus_RdData)
  );

  // Bus register contents seen by reads.
  function automatic logic [31:0] bus_val(input logic [29:0] a);
    if (a == 30'h20) return 32'hDEAD_BEEF;
    return {2'b01, a} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave: data is only valid exactly L cycles after the RdEn cycle.
  logic [3:0]  rd_pipe = 4'd0;
  logic [29:0] rd_addr = 30'd0;
  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[2:0], Bus_RdEn};
    if (Bus_RdEn === 1'b1) rd_addr <= Bus_Address;
  end
  assign Bus_RdData = rd_pipe[L-1] ? bus_val(rd_addr) : 32'h5A5A_5A5A;

  // Schedule model: a transaction chosen at cycle c grants at c+1 and completes
  // at c+2 (write) or c+2+L (read); the next idle cycle is the one after done.
  int          cyc = 0, g_cyc = 0, d_cyc = 0, hold = 0;
  bit          busy = 1'b0, win = 1'b0, m_wr = 1'b0, last = 1'b1, locked = 1'b0, seen_rst = 1'b0;
  logic [29:0] m_addr = 30'd0;
  logic [31:0] m_wdata = 32'd0, m_rd0 = 32'd0, m_rd1 = 32'd0;

  // Per-cycle comparison against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    bit is_g, is_d, lk, owner;
    is_g = busy && (cyc == g_cyc);
    is_d = busy && (cyc == d_cyc);
    if (seen_rst) begin
      chk("M0_Grant", M0_Grant, is_g && !win);
      chk("M1_Grant", M1_Grant, is_g && win);
      chk("Bus_WrEn", Bus_WrEn, is_g && m_wr);
      chk("Bus_RdEn", Bus_RdEn, is_g && !m_wr);
      chk("Bus_Address", Bus_Address, m_addr);
      chk("Bus_WrData", Bus_WrData, m_wdata);
      chk("M0_Done", M0_Done, is_d && !win);
      chk("M1_Done", M1_Done, is_d && win);
      chk("M0_RdData", M0_RdData, m_rd0);
      chk("M1_RdData", M1_RdData, m_rd1);
    end
    if (Sys_Reset) begin
      seen_rst = 1'b1; busy = 1'b0; last = 1'b1; locked = 1'b0; hold = 0;
      m_addr = 30'd0; m_wdata = 32'd0; m_rd0 = 32'd0; m_rd1 = 32'd0;
    end else if (busy) begin
      if (!m_wr && (cyc + 1 == d_cyc)) begin
        if (win) m_rd1 = bus_val(m_addr);
        else     m_rd0 = bus_val(m_addr);
      end
      if (is_d) begin
        busy = 1'b0;
        last = win;
        lk = win ? M1_Lock : M0_Lock;
`ifdef IO_ARB_LOCK_EN
        if (lk && hold < HM) begin locked = 1'b1; hold++; end
        else begin locked = 1'b0; hold = 0; end
`endif
      end
    end else begin
      owner = last ? M1_Req : M0_Req;
      if (locked && !owner) begin locked = 1'b0; hold = 0; end
      if (M0_Req || M1_Req) begin
        if (locked) win = last;
        else if (M0_Req && M1_Req) win = !last;
        else win = M1_Req;
        m_wr    = win ? M1_Wr : M0_Wr;
        m_addr  = win ? M1_Address : M0_Address;
        m_wdata = win ? M1_WrData : M0_WrData;
        busy    = 1'b1;
        g_cyc   = cyc + 1;
        d_cyc   = cyc + 2 + (m_wr ? 0 : L);
      end
    end
    cyc++;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input bit m, input bit req, input bit wr, input logic [29:0] a, input logic [31:0] d);
    if (m) begin M1_Req = req; M1_Wr = wr; M1_Address = a; M1_WrData = d; end
    else   begin M0_Req = req; M0_Wr = wr; M0_Address = a; M0_WrData = d; end
  endtask

  // One transaction from an idle cycle; optionally drop/scramble the request after issue.
  task automatic txn(input bit m, input bit wr, input logic [29:0] a, input logic [31:0] d,
                     input bit drop, output int lat);
    drive_m(m, 1'b1, wr, a, d);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      nxt();
      if (m ? M1_Done : M0_Done) lat = i;
      else if (drop) drive_m(m, 1'b0, ~wr, ~a, ~d);
    end
    chk("txn_done_seen", (lat != 0), 1'b1);
    drive_m(m, 1'b0, wr, a, d);
    nxt();
  endtask

  task automatic do_reset();
    Sys_Reset = 1'b1;
    nxt(); nxt();
    Sys_Reset = 1'b0;
  endtask

  // Hold both requests until four grants are seen; return grant order (bit k = 1 means M1).
  task automatic both_run(output logic [3:0] seq, output int n);
    seq = 4'd0; n = 0;
    drive_m(1'b0, 1'b1, 1'b1, 30'h100, 32'h0000_1000);
    drive_m(1'b1, 1'b1, 1'b0, 30'h101, 32'h0000_2000);
    for (int i = 0; i < 60 && n < 4; i++) begin
      nxt();
      if (M0_Grant || M1_Grant) begin
        seq[n] = M1_Grant;
        n++;
      end
    end
    M0_Req = 1'b0; M1_Req = 1'b0;
    repeat (8) nxt();
  endtask

  logic [3:0] seq;
  logic [3:0] lock_exp;
  int lat, n;

  initial begin
    Sys_Reset = 1'b1;
    M0_Req = 1'b0; M1_Req = 1'b0; M0_Wr = 1'b0; M1_Wr = 1'b0;
    M0_Lock = 1'b0; M1_Lock = 1'b0;
    M0_Address = 30'd0; M1_Address = 30'd0; M0_WrData = 32'd0; M1_WrData = 32'd0;
    nxt(); nxt(); nxt();
    Sys_Reset = 1'b0;
    chk("rst_grant", {M0_Grant, M1_Grant, M0_Done, M1_Done}, 4'b0000);
    chk("rst_addr", Bus_Address, 30'd0);
    chk("rst_strobes", {Bus_WrEn, Bus_RdEn}, 2'b00);

    // M0 write 0xA5 to 0x10
    drive_m(1'b0, 1'b1, 1'b1, 30'h10, 32'h0000_00A5);
    nxt();
    chk("wr_grant", M0_Grant, 1'b1);
    chk("wr_wren", Bus_WrEn, 1'b1);
    chk("wr_rden", Bus_RdEn, 1'b0);
    chk("wr_addr", Bus_Address, 30'h10);
    chk("wr_data", Bus_WrData, 32'h0000_00A5);
    nxt();
    chk("wr_done", M0_Done, 1'b1);
    M0_Req = 1'b0;
    nxt();
    chk("wr_hold_addr", Bus_Address, 30'h10);

    // M1 read of 0x20 with latency 2
    txn(1'b1, 1'b0, 30'h20, 32'd0, 1'b0, lat);
    chk("rd_latency", lat, 4);
    chk("rd_data", M1_RdData, 32'hDEAD_BEEF);

    // M1 write with request dropped and fields scrambled after grant
    txn(1'b1, 1'b1, 30'h21, 32'h1111_2222, 1'b1, lat);
    chk("wr_drop_latency", lat, 2);
    chk("rd_data_kept", M1_RdData, 32'hDEAD_BEEF);

    // M0 read with request dropped after grant
    txn(1'b0, 1'b0, 30'h30, 32'd0, 1'b1, lat);
    chk("rd_drop_latency", lat, 4);
    chk("m0_rd_data", M0_RdData, 32'h5234_5648);

    // Round robin from reset
    do_reset();
    both_run(seq, n);
    chk("rr_count", n, 4);
    chk("rr_order", seq, 4'b1010);

    // Lock held by M0
    do_reset();
    M0_Lock = 1'b1;
    both_run(seq, n);
    M0_Lock = 1'b0;
`ifdef IO_ARB_LOCK_EN
    lock_exp = 4'b1000;
`else
    lock_exp = 4'b1010;
`endif
    chk("lock_count", n, 4);
    chk("lock_order", seq, lock_exp);

    // Reset during WAIT of an M0 read
    txn(1'b0, 1'b1, 30'h44, 32'h0BAD_CAFE, 1'b0, lat);
    txn(1'b0, 1'b0, 30'h30, 32'd0, 1'b0, lat);
    chk("pre_rst_rd", M0_RdData, 32'h5234_5648);
    drive_m(1'b0, 1'b1, 1'b0, 30'h40, 32'd0);
    nxt();
    chk("abort_grant", M0_Grant, 1'b1);
    nxt();
    Sys_Reset = 1'b1;
    M0_Req = 1'b0;
    nxt();
    Sys_Reset = 1'b0;
    chk("abort_done", M0_Done, 1'b0);
    chk("abort_rd", M0_RdData, 32'd0);
    chk("abort_addr", Bus_Address, 30'd0);
    chk("abort_rden", Bus_RdEn, 1'b0);
    repeat (4) nxt();
    drive_m(1'b0, 1'b1, 1'b1, 30'h50, 32'h5);
    drive_m(1'b1, 1'b1, 1'b1, 30'h51, 32'h6);
    nxt();
    chk("post_rst_m0", M0_Grant, 1'b1);
    chk("post_rst_m1", M1_Grant, 1'b0);
    M0_Req = 1'b0; M1_Req = 1'b0;
    repeat (10) nxt();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 Parameter RD_LATENCY, default 1: cycles from the Bus_RdEn strobe to valid Bus_RdData, legal range 1..4.
REQ-002 Parameter HOLD_MAX, default 4: maximum consecutive locked transactions granted to one master.
REQ-003 Sys_Clock  in  1  sole clock; all logic is on its rising edge.
REQ-004 Sys_Reset  in  1  synchronous reset, active-high.
REQ-005 M0_Req, M1_Req  in  1 each  transaction request; the master holds it until its Mx_Done.
REQ-006 M0_Wr, M1_Wr  in  1 each  1 = write, 0 = read.
REQ-007 M0_Address, M1_Address  in  30 each  word address.
REQ-008 M0_WrData, M1_WrData  in  32 each  write data.
REQ-009 M0_Lock, M1_Lock  in  1 each  request that the next transaction is regranted without arbitration.
REQ-010 M0_Grant, M1_Grant  out  1 each  one-cycle pulse in the cycle the master's transaction is issued.
REQ-011 M0_Done, M1_Done  out  1 each  one-cycle completion pulse.
REQ-012 M0_RdData, M1_RdData  out  32 each  read result; valid with Mx_Done.
REQ-013 Bus_Address  out  30  address to the IO register bus.
REQ-014 Bus_WrData  out  32  write data to the IO register bus.
REQ-015 Bus_WrEn, Bus_RdEn  out  1 each  one-cycle access strobes.
REQ-016 Bus_RdData  in  32  read data from the IO register bus.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: if any Mx_Req is high, the FSM SHALL select a winner, register its Wr/Address/WrData, and go to ISSUE; otherwise it stays in IDLE.
REQ-019 Winner selection: with one request, that master wins; with both, the master not served last wins (round-robin pointer updated at DONE).
REQ-020 ISSUE SHALL last exactly one cycle and drive the winner's Mx_Grant=1 and the registered Bus_Address and Bus_WrData; it drives Bus_WrEn=1 for a write or Bus_RdEn=1 for a read, never both.
REQ-021 After ISSUE, a write SHALL go directly to DONE and a read SHALL go to WAIT.
REQ-022 WAIT SHALL last RD_LATENCY cycles and capture Bus_RdData in its last cycle.
REQ-023 DONE SHALL last one cycle, pulse the winner's Mx_Done and present the captured data on its Mx_RdData, then return to IDLE.
REQ-024 Latency, with Req sampled in IDLE at cycle t: Grant at t+1; write Done at t+2; read Done at t+2+RD_LATENCY.
REQ-025 Mx_RdData SHALL hold its value until that master's next read Done; a write Done leaves it unchanged.
REQ-026 Outside ISSUE, Bus_WrEn and Bus_RdEn SHALL be 0 and Bus_Address and Bus_WrData SHALL hold their last values.
REQ-027 Deasserting Mx_Req after Grant SHALL NOT abort the transaction; Done is still issued.
REQ-028 Request fields changing after the IDLE sample SHALL NOT affect the transaction in flight.
REQ-029 There SHALL be one IDLE cycle between consecutive transactions, and at most one transaction is in flight at a time.
REQ-030 A request arriving in any non-IDLE state SHALL wait and is arbitrated at the next IDLE.

Reset
REQ-031 When Sys_Reset is high, the FSM SHALL enter IDLE and clear all outputs, the captured data, the hold counter and the lock state.
REQ-032 On reset, the round-robin pointer SHALL favour M0.
REQ-033 A reset during ISSUE, WAIT or DONE SHALL abandon the transaction with no Done pulse; the master must re-request.

Configuration
REQ-034 With IO_ARB_LOCK_EN defined: if the winner's Mx_Lock=1 in DONE and the hold counter is below HOLD_MAX, its next request SHALL win at IDLE regardless of the pointer and the hold counter increments.
REQ-035 With IO_ARB_LOCK_EN defined: the lock SHALL be released when Lock=0 in DONE, when the hold counter reaches HOLD_MAX (the other master then wins if requesting), or when the locked master has no request at IDLE; release resets the hold counter to 0.
REQ-036 Without IO_ARB_LOCK_EN: the Mx_Lock inputs SHALL be ignored, the hold counter is not built, and arbitration is pure round-robin.

Verification
REQ-037 M0 writes 0x0000_00A5 to address 0x10 with M1 idle -> M0_Grant, Bus_WrEn and Bus_Address=0x10 at t+1; M0_Done at t+2.
REQ-038 M1 reads address 0x20 with RD_LATENCY=2 while the bus returns 0xDEAD_BEEF -> M1_Done at t+4 with M1_RdData=0xDEAD_BEEF.
REQ-039 Both masters request continuously for 4 transactions from reset -> grants alternate M0, M1, M0, M1.
REQ-040 With IO_ARB_LOCK_EN, HOLD_MAX=2, M0_Lock=1 and both requesting -> grants M0, M0, M0, then M1.
REQ-041 Sys_Reset asserted during WAIT of an M0 read -> no M0_Done, all outputs 0, and the next simultaneous request is granted to M0.
